// File: rtl/motor_hbridge_driver.sv
// motor_hbridge_driver
//   Converts the 4-bit direction command of the navigation FSM into gate
//   drives for two H-bridges (A and B). Adds a shared PWM for speed control
//   and a break-before-make dead time on every direction reversal.
//
// Ports
//   clk     in   1         system clock, rising edge
//   reset   in   1         asynchronous, active-high; clears all state
//   ena     in   1         global enable; 0 parks both channels in IDLE, outputs low
//   cmd     in   4         {A_d, A_i, B_d, B_i}: per pair 10 fwd, 01 rev, 00 coast, 11 illegal
//   duty    in   PWM_BITS  speed duty, taken only at the PWM period boundary
//   hb_out  out  4         {A_d, A_i, B_d, B_i} registered gate drives
//   busy    out  1         registered: either channel is in DEAD
//   fault   out  1         sticky: an illegal pair 11 was seen; cleared only by reset
//
// Handshake: none. cmd is level-sampled on every enabled clock edge; the
// result appears on hb_out two edges later.
module motor_hbridge_driver #(
    parameter int PWM_BITS = 8,
    parameter int DEADTIME = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ena,
    input  logic [3:0]          cmd,
    input  logic [PWM_BITS-1:0] duty,
    output logic [3:0]          hb_out,
    output logic                busy,
    output logic                fault
);

    localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;
    localparam logic [DW-1:0]       DEAD_INI = DW'(DEADTIME - 1);

    typedef enum logic [1:0] {IDLE, FWD, REV, DEAD} ch_state_t;

    // Index 1 is channel A (cmd[3:2]), index 0 is channel B (cmd[1:0]).
    ch_state_t     st_q   [2];
    ch_state_t     st_d   [2];
    logic [DW-1:0] dcnt_q [2];
    logic [DW-1:0] dcnt_d [2];
    logic          is_fwd [2];
    logic          is_rev [2];

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_q;
    logic                pwm_on;
    logic                illegal;

    assign is_fwd[1] = (cmd[3:2] == 2'b10);
    assign is_rev[1] = (cmd[3:2] == 2'b01);
    assign is_fwd[0] = (cmd[1:0] == 2'b10);
    assign is_rev[0] = (cmd[1:0] == 2'b01);
    assign illegal   = (cmd[3:2] == 2'b11) || (cmd[1:0] == 2'b11);

    assign pwm_on = (pwm_cnt < duty_q);

    // PWM counter; duty is captured only as the period wraps so a duty change
    // never shortens or stretches the pulse already in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
            duty_q  <= '0;
        end else if (!ena) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == PWM_MAX) begin
                duty_q <= duty;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                st_q[k]   <= IDLE;
                dcnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                st_q[k]   <= st_d[k];
                dcnt_q[k] <= dcnt_d[k];
            end
        end
    end

    // Channel next-state. Coast and illegal both mean "release the bridge",
    // which needs no dead time; only a direct fwd<->rev flip goes via DEAD.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            st_d[k]   = st_q[k];
            dcnt_d[k] = dcnt_q[k];
            if (!ena) begin
                st_d[k]   = IDLE;
                dcnt_d[k] = '0;
            end else begin
                case (st_q[k])
                    IDLE: begin
                        if (is_fwd[k])      st_d[k] = FWD;
                        else if (is_rev[k]) st_d[k] = REV;
                    end
                    FWD: begin
                        if (is_rev[k]) begin
                            st_d[k]   = DEAD;
                            dcnt_d[k] = DEAD_INI;
                        end else if (!is_fwd[k]) begin
                            st_d[k] = IDLE;
                        end
                    end
                    REV: begin
                        if (is_fwd[k]) begin
                            st_d[k]   = DEAD;
                            dcnt_d[k] = DEAD_INI;
                        end else if (!is_rev[k]) begin
                            st_d[k] = IDLE;
                        end
                    end
                    DEAD: begin
                        // cmd is only looked at on the last DEAD cycle.
                        if (dcnt_q[k] != '0) begin
                            dcnt_d[k] = dcnt_q[k] - DW'(1);
                        end else if (is_fwd[k]) begin
                            st_d[k] = FWD;
                        end else if (is_rev[k]) begin
                            st_d[k] = REV;
                        end else begin
                            st_d[k] = IDLE;
                        end
                    end
                    default: begin
                        st_d[k]   = IDLE;
                        dcnt_d[k] = '0;
                    end
                endcase
            end
        end
    end

    // Registered pad outputs. Each leg is qualified by a distinct state, so
    // the two legs of one bridge can never be high together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hb_out <= '0;
            busy   <= 1'b0;
            fault  <= 1'b0;
        end else begin
            if (ena) begin
                hb_out <= {(st_q[1] == FWD) & pwm_on, (st_q[1] == REV) & pwm_on,
                           (st_q[0] == FWD) & pwm_on, (st_q[0] == REV) & pwm_on};
                busy   <= (st_q[1] == DEAD) | (st_q[0] == DEAD);
                if (illegal) begin
                    fault <= 1'b1;
                end
            end else begin
                hb_out <= '0;
                busy   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_motor_hbridge_driver.sv
module tb_motor_hbridge_driver;

  logic       clk;
  logic       reset;
  logic       ena;
  logic [3:0] cmd;
  logic [7:0] duty;
  logic [3:0] hb_out;
  logic       busy;
  logic       fault;

  int checks;
  int failures;

  motor_hbridge_driver #(.PWM_BITS(8), .DEADTIME(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .ena    (ena),
    .cmd    (cmd),
    .duty   (duty),
    .hb_out (hb_out),
    .busy   (busy),
    .fault  (fault)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cmd;
    logic [7:0] duty;
    int         h3;
    int         h2;
    int         h1;
    int         h0;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // advance one clock; outputs are settled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // high-sample counts of each hb_out bit and of busy over n cycles
  task automatic count_window(input int n, output int c3, output int c2,
                              output int c1, output int c0, output int cb);
    c3 = 0; c2 = 0; c1 = 0; c0 = 0; cb = 0;
    for (int i = 0; i < n; i++) begin
      step();
      c3 += int'(hb_out[3]);
      c2 += int'(hb_out[2]);
      c1 += int'(hb_out[1]);
      c0 += int'(hb_out[0]);
      cb += int'(busy);
    end
  endtask

  initial begin
    int c3, c2, c1, c0, cb;
    int nz32, found;
    logic prev;

    checks   = 0;
    failures = 0;

    vecs[0] = '{cmd: 4'b1010, duty: 8'd128, h3: 128, h2: 0,   h1: 128, h0: 0};
    vecs[1] = '{cmd: 4'b0101, duty: 8'd255, h3: 0,   h2: 255, h1: 0,   h0: 255};
    vecs[2] = '{cmd: 4'b1001, duty: 8'd64,  h3: 64,  h2: 0,   h1: 0,   h0: 64};
    vecs[3] = '{cmd: 4'b0000, duty: 8'd200, h3: 0,   h2: 0,   h1: 0,   h0: 0};
    vecs[4] = '{cmd: 4'b1010, duty: 8'd0,   h3: 0,   h2: 0,   h1: 0,   h0: 0};
    vecs[5] = '{cmd: 4'b0110, duty: 8'd1,   h3: 0,   h2: 1,   h1: 1,   h0: 0};

    // reset asserted with a drive command present
    reset = 1'b0;
    ena   = 1'b1;
    cmd   = 4'b1010;
    duty  = 8'd200;
    #1 reset = 1'b1;
    #1;
    chk("reset_hb", int'(hb_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_fault", int'(fault), 0);
    run(3);
    chk("reset_hold_hb", int'(hb_out), 0);
    reset = 1'b0;

    // steady-state PWM per direction pattern; 600 cycles lets any DEAD
    // finish and the new duty load before the 256-cycle measurement
    for (int v = 0; v < 6; v++) begin
      cmd  = vecs[v].cmd;
      duty = vecs[v].duty;
      run(600);
      count_window(256, c3, c2, c1, c0, cb);
      chk($sformatf("vec%0d_hb3", v), c3, vecs[v].h3);
      chk($sformatf("vec%0d_hb2", v), c2, vecs[v].h2);
      chk($sformatf("vec%0d_hb1", v), c1, vecs[v].h1);
      chk($sformatf("vec%0d_hb0", v), c0, vecs[v].h0);
      chk($sformatf("vec%0d_busy", v), cb, 0);
      chk($sformatf("vec%0d_fault", v), int'(fault), 0);
    end

    // reversal of A with cmd toggling during DEAD; B keeps driving forward
    cmd  = 4'b1010;
    duty = 8'd255;
    run(600);
    cmd = 4'b0110;
    step();  // edge that samples the reversal
    cb = 0; nz32 = 0; c1 = 0; c0 = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      cb   += int'(busy);
      nz32 += int'(hb_out[3:2] != 2'b00);
      c1   += int'(hb_out[1]);
      c0   += int'(hb_out[0]);
      if (i == 3) cmd = 4'b1010;
      if (i == 6) cmd = 4'b0110;
    end
    chk("rev_busy_cycles", cb, 16);
    chk("rev_a_legs_low", nz32, 0);
    chk("rev_b_fwd_kept", int'(c1 >= 15), 1);
    chk("rev_b_rev_leg", c0, 0);
    step();
    chk("rev_busy_end", int'(busy), 0);
    count_window(256, c3, c2, c1, c0, cb);
    chk("rev_a_i_pwm", c2, 255);
    chk("rev_a_d_off", c3, 0);
    chk("rev_b_pwm", c1, 255);

    // illegal pair on A
    cmd = 4'b1010;
    run(40);
    chk("ill_pre_fault", int'(fault), 0);
    cmd = 4'b1100;
    step();
    chk("ill_fault_set", int'(fault), 1);
    step();
    chk("ill_a_legs", int'(hb_out[3:2]), 0);
    cmd = 4'b1010;
    run(30);
    chk("ill_fault_sticky", int'(fault), 1);

    // duty change mid-period takes effect from the next period
    duty = 8'd64;
    run(600);
    prev  = hb_out[3];
    found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      step();
      if (hb_out[3] && !prev) found = 1;
      prev = hb_out[3];
    end
    chk("duty_period_start_found", found, 1);
    c3 = int'(hb_out[3]);
    c1 = int'(hb_out[1]);
    for (int i = 1; i < 256; i++) begin
      step();
      c3 += int'(hb_out[3]);
      c1 += int'(hb_out[1]);
      if (i == 100) duty = 8'd192;
    end
    chk("duty_old_a", c3, 64);
    chk("duty_old_b", c1, 64);
    count_window(256, c3, c2, c1, c0, cb);
    chk("duty_new_a", c3, 192);
    chk("duty_new_b", c1, 192);

    // enable drop during DEAD, then restart straight into REV
    duty = 8'd255;
    run(600);
    cmd = 4'b0110;
    step();
    run(3);
    chk("ena_busy_in_dead", int'(busy), 1);
    ena = 1'b0;
    step();
    chk("ena_off_busy", int'(busy), 0);
    chk("ena_off_hb", int'(hb_out), 0);
    cmd = 4'b0101;
    ena = 1'b1;
    step();
    step();
    chk("ena_on_rev_hb", int'(hb_out), 4'b0101);
    count_window(20, c3, c2, c1, c0, cb);
    chk("ena_on_no_dead", cb, 0);

    // asynchronous reset in the middle of a drive cycle
    #3;
    chk("mid_pre_hb", int'(hb_out), 4'b0101);
    cmd   = 4'b1010;
    duty  = 8'd200;
    reset = 1'b1;
    #1;
    chk("mid_reset_hb", int'(hb_out), 0);
    chk("mid_reset_busy", int'(busy), 0);
    chk("mid_reset_fault", int'(fault), 0);
    run(2);
    reset = 1'b0;
    run(600);
    count_window(256, c3, c2, c1, c0, cb);
    chk("post_reset_a", c3, 200);
    chk("post_reset_b", c1, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
